mem_access_stage: RTL and testbench



---
 rtl/mem_pkg.sv | 54 +++++
 rtl/mem_access_stage_if.sv | 36 +++
 rtl/mem_lane_unit.sv | 41 ++++
 rtl/mem_access_stage.sv | 137 +++++++++++++
 tb/tb_mem_access_stage.sv | 231 +++++++++++++++++++++++
 5 files changed

// File: rtl/mem_pkg.sv
// rtl/mem_pkg.sv - op/state encodings and lane helpers for mem_access_stage
package mem_pkg;

  typedef enum logic [2:0] {
    OP_LB  = 3'd0,
    OP_LBU = 3'd1,
    OP_LH  = 3'd2,
    OP_LHU = 3'd3,
    OP_LW  = 3'd4,
    OP_SB  = 3'd5,
    OP_SH  = 3'd6,
    OP_SW  = 3'd7
  } op_e;

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_RD   = 3'd1,
    S_WAIT = 3'd2,
    S_WR   = 3'd3,
    S_RESP = 3'd4
  } state_e;

  localparam bit BYTE_ORDER_BIG = 1'b1;

  function automatic logic is_load(op_e op);
    return (op == OP_LB) || (op == OP_LBU) || (op == OP_LH) ||
           (op == OP_LHU) || (op == OP_LW);
  endfunction

  function automatic logic is_store(op_e op);
    return (op == OP_SB) || (op == OP_SH) || (op == OP_SW);
  endfunction

  function automatic logic misaligned(op_e op, logic [1:0] off);
    case (op)
      OP_LH, OP_LHU, OP_SH: return off[0];
      OP_LW, OP_SW:         return |off;
      default:              return 1'b0;
    endcase
  endfunction

  // Right-shift that brings the addressed byte/halfword down to bit 0.
  function automatic logic [4:0] lane_shift(op_e op, logic [1:0] off);
    logic [1:0] lane;
    lane = 2'd0;
    case (op)
      OP_LB, OP_LBU, OP_SB: lane = BYTE_ORDER_BIG ? (2'd3 - off) : off;
      OP_LH, OP_LHU, OP_SH: lane = BYTE_ORDER_BIG ? (2'd2 - {off[1], 1'b0}) : {off[1], 1'b0};
      default:              lane = 2'd0;
    endcase
    return {lane, 3'b000};
  endfunction

endpackage

// File: rtl/mem_access_stage_if.sv
// rtl/mem_access_stage_if.sv - EX request, WB response and data_mem word bus
interface mem_access_stage_if #(
  parameter int ADDR_W = 32
);
  logic              in_valid;
  logic              in_ready;
  logic [2:0]        in_op;
  logic [ADDR_W-1:0] in_addr;
  logic [31:0]       in_wdata;
  logic [4:0]        in_rd;

  logic [ADDR_W-1:0] Address;
  logic [31:0]       WriteData;
  logic [1:0]        MemWrite;
  logic [1:0]        MemRead;
  logic [31:0]       ReadData;

  logic              out_valid;
  logic              out_ready;
  logic [31:0]       out_data;
  logic [4:0]        out_rd;
  logic              out_is_load;
  logic              out_fault;

  modport master (
    output in_valid, in_op, in_addr, in_wdata, in_rd, ReadData, out_ready,
    input  in_ready, Address, WriteData, MemWrite, MemRead,
           out_valid, out_data, out_rd, out_is_load, out_fault
  );

  modport slave (
    input  in_valid, in_op, in_addr, in_wdata, in_rd, ReadData, out_ready,
    output in_ready, Address, WriteData, MemWrite, MemRead,
           out_valid, out_data, out_rd, out_is_load, out_fault
  );
endinterface

// File: rtl/mem_lane_unit.sv
// rtl/mem_lane_unit.sv - big-endian lane extract/extend for loads, lane merge for sub-word stores
module mem_lane_unit
  import mem_pkg::*;
(
  input  op_e         op_i,
  input  logic [1:0]  off_i,
  input  logic [31:0] rdata_i,
  input  logic [31:0] wdata_i,
  output logic [31:0] load_o,
  output logic [31:0] merged_o
);
  logic [4:0]  sh;
  logic [31:0] shifted;
  logic [31:0] mask;

  assign sh      = lane_shift(op_i, off_i);
  assign shifted = rdata_i >> sh;

  always_comb begin
    load_o = shifted;
    case (op_i)
      OP_LB:   load_o = {{24{shifted[7]}}, shifted[7:0]};
      OP_LBU:  load_o = {24'd0, shifted[7:0]};
      OP_LH:   load_o = {{16{shifted[15]}}, shifted[15:0]};
      OP_LHU:  load_o = {16'd0, shifted[15:0]};
      default: load_o = shifted;
    endcase
  end

  always_comb begin
    mask = 32'hFFFF_FFFF;
    case (op_i)
      OP_SB:   mask = 32'h0000_00FF << sh;
      OP_SH:   mask = 32'h0000_FFFF << sh;
      default: mask = 32'hFFFF_FFFF;
    endcase
  end

  assign merged_o = (rdata_i & ~mask) | ((wdata_i << sh) & mask);

endmodule

// File: rtl/mem_access_stage.sv
// rtl/mem_access_stage.sv - non-pipelined MEM stage with RMW sub-word stores
// Optional bounds check enabled by defining MEM_ACCESS_BOUNDS_CHECK_EN.
module mem_access_stage
  import mem_pkg::*;
#(
  parameter int ADDR_W      = 32,
  parameter int DEPTH_BYTES = 256
) (
  input  logic                clk,
  input  logic                rst,
  mem_access_stage_if.slave   bus
);
`ifdef MEM_ACCESS_BOUNDS_CHECK_EN
  localparam bit BOUNDS_EN = 1'b1;
`else
  localparam bit BOUNDS_EN = 1'b0;
`endif

  state_e            state_q, state_d;
  op_e               op_q, op_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [31:0]       wdata_q, wdata_d;
  logic [4:0]        rd_q, rd_d;
  logic [31:0]       wr_word_q, wr_word_d;
  logic [31:0]       out_data_q, out_data_d;
  logic              out_fault_q, out_fault_d;
  logic              out_is_load_q, out_is_load_d;

  op_e         in_op;
  logic        oob;
  logic [31:0] lane_load;
  logic [31:0] lane_merged;

  assign in_op = op_e'(bus.in_op);
  assign oob   = BOUNDS_EN && (bus.in_addr >= ADDR_W'(DEPTH_BYTES));

  // ReadData is only meaningful in WAIT, which is the only state consuming these.
  mem_lane_unit u_lane (
    .op_i     (op_q),
    .off_i    (addr_q[1:0]),
    .rdata_i  (bus.ReadData),
    .wdata_i  (wdata_q),
    .load_o   (lane_load),
    .merged_o (lane_merged)
  );

  always_comb begin
    state_d       = state_q;
    op_d          = op_q;
    addr_d        = addr_q;
    wdata_d       = wdata_q;
    rd_d          = rd_q;
    wr_word_d     = wr_word_q;
    out_data_d    = out_data_q;
    out_fault_d   = out_fault_q;
    out_is_load_d = out_is_load_q;
    case (state_q)
      S_IDLE: begin
        if (bus.in_valid) begin
          op_d          = in_op;
          addr_d        = bus.in_addr;
          wdata_d       = bus.in_wdata;
          rd_d          = bus.in_rd;
          out_data_d    = 32'd0;
          out_fault_d   = 1'b0;
          out_is_load_d = is_load(in_op);
          if (misaligned(in_op, bus.in_addr[1:0]) || oob) begin
            out_fault_d   = 1'b1;
            out_is_load_d = 1'b0;
            state_d       = S_RESP;
          end else if (in_op == OP_SW) begin
            wr_word_d = bus.in_wdata;
            state_d   = S_WR;
          end else begin
            state_d = S_RD;
          end
        end
      end
      S_RD:   state_d = S_WAIT;
      S_WAIT: begin
        if (is_store(op_q)) begin
          wr_word_d = lane_merged;
          state_d   = S_WR;
        end else begin
          out_data_d = lane_load;
          state_d    = S_RESP;
        end
      end
      S_WR:   state_d = S_RESP;
      S_RESP: if (bus.out_ready) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      op_q          <= OP_LB;
      addr_q        <= '0;
      wdata_q       <= 32'd0;
      rd_q          <= 5'd0;
      wr_word_q     <= 32'd0;
      out_data_q    <= 32'd0;
      out_fault_q   <= 1'b0;
      out_is_load_q <= 1'b0;
    end else begin
      op_q          <= op_d;
      addr_q        <= addr_d;
      wdata_q       <= wdata_d;
      rd_q          <= rd_d;
      wr_word_q     <= wr_word_d;
      out_data_q    <= out_data_d;
      out_fault_q   <= out_fault_d;
      out_is_load_q <= out_is_load_d;
    end
  end

  // Strobes decode straight from state so the async reset drops them at once.
  assign bus.in_ready    = (state_q == S_IDLE);
  assign bus.MemRead     = {1'b0, state_q == S_RD};
  assign bus.MemWrite    = {1'b0, state_q == S_WR};
  assign bus.Address     = {addr_q[ADDR_W-1:2], 2'b00};
  assign bus.WriteData   = wr_word_q;
  assign bus.out_valid   = (state_q == S_RESP);
  assign bus.out_data    = out_data_q;
  assign bus.out_rd      = rd_q;
  assign bus.out_is_load = out_is_load_q;
  assign bus.out_fault   = out_fault_q;

endmodule

// File: tb/tb_mem_access_stage.sv
// tb/tb_mem_access_stage.sv - directed plus random checks of mem_access_stage against a byte-level model
module tb_mem_access_stage;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_vec = 0;
  int   n_err = 0;

  always #5 clk = ~clk;

  mem_access_stage_if #(.ADDR_W(32)) bus ();

  mem_access_stage #(.ADDR_W(32), .DEPTH_BYTES(256)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // data_mem stand-in: word array, read data one cycle after MemRead is sampled
  logic [31:0] dmem [64];
  int          rd_cnt = 0;
  int          wr_cnt = 0;
  int          both_cnt = 0;
  logic [31:0] last_rd_addr = 32'd0;
  logic [31:0] last_wr_data = 32'd0;

  always @(posedge clk) begin
    if (bus.MemRead == 2'b01) begin
      bus.ReadData <= dmem[bus.Address[7:2]];
      last_rd_addr <= bus.Address;
      rd_cnt       <= rd_cnt + 1;
    end
    if (bus.MemWrite == 2'b01) begin
      dmem[bus.Address[7:2]] <= bus.WriteData;
      last_wr_data <= bus.WriteData;
      wr_cnt       <= wr_cnt + 1;
    end
    if (bus.MemRead != 2'b00 && bus.MemWrite != 2'b00) both_cnt <= both_cnt + 1;
  end

  // Reference: plain byte array, big-endian (lowest address = most significant byte)
  logic [7:0] ref_mem [256];

  function automatic logic [31:0] ref_word(int a);
    int b;
    b = a & 252;
    return {ref_mem[b], ref_mem[b+1], ref_mem[b+2], ref_mem[b+3]};
  endfunction

  function automatic logic [31:0] ref_load(int op, int a);
    logic [7:0] b0, b1;
    b0 = ref_mem[a & 255];
    b1 = ref_mem[(a + 1) & 255];
    case (op)
      0: return {{24{b0[7]}}, b0};
      1: return {24'd0, b0};
      2: return {{16{b0[7]}}, b0, b1};
      3: return {16'd0, b0, b1};
      default: return ref_word(a);
    endcase
  endfunction

  task automatic ref_store(int op, int a, logic [31:0] w);
    case (op)
      5: ref_mem[a & 255] = w[7:0];
      6: begin ref_mem[a & 255] = w[15:8]; ref_mem[(a + 1) & 255] = w[7:0]; end
      default: begin
        ref_mem[a & 252]       = w[31:24];
        ref_mem[(a & 252) + 1] = w[23:16];
        ref_mem[(a & 252) + 2] = w[15:8];
        ref_mem[(a & 252) + 3] = w[7:0];
      end
    endcase
  endtask

  task automatic check(string tag, logic [31:0] obs, logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic run_req(int op, int a, logic [31:0] w, logic [4:0] rd, int stall);
    bit          fault;
    int          exp_lat, lat, rd0, wr0;
    logic [31:0] exp_data, data_seen;
    fault = ((op == 2 || op == 3 || op == 6) && (a % 2 != 0)) ||
            ((op == 4 || op == 7) && (a % 4 != 0));
`ifdef MEM_ACCESS_BOUNDS_CHECK_EN
    fault = fault || (a >= 256);
`endif
    exp_lat  = fault ? 1 : (op == 7) ? 2 : (op >= 5) ? 4 : 3;
    exp_data = (!fault && op <= 4) ? ref_load(op, a) : 32'd0;
    if (!fault && op >= 5) ref_store(op, a, w);

    @(negedge clk);
    bus.in_valid = 1'b1;
    bus.in_op    = 3'(op);
    bus.in_addr  = 32'(a);
    bus.in_wdata = w;
    bus.in_rd    = rd;
    bus.out_ready = (stall == 0);
    check("in_ready_idle", 32'(bus.in_ready), 32'd1);
    rd0 = rd_cnt;
    wr0 = wr_cnt;
    @(posedge clk);
    #1 bus.in_valid = 1'b0;

    lat = 0;
    for (int k = 1; k <= 8; k++) begin
      @(negedge clk);
      if (bus.out_valid === 1'b1) begin
        lat = k;
        break;
      end
    end
    check($sformatf("latency op%0d @%0h", op, a), 32'(lat), 32'(exp_lat));
    check($sformatf("out_data op%0d @%0h", op, a), bus.out_data, exp_data);
    check("out_fault", 32'(bus.out_fault), 32'(fault));
    check("out_is_load", 32'(bus.out_is_load), 32'(!fault && op <= 4));
    check("out_rd", 32'(bus.out_rd), 32'(rd));
    data_seen = bus.out_data;

    for (int s = 0; s < stall; s++) begin
      @(negedge clk);
      check("stall_hold", {bus.out_data[31:2] ^ data_seen[31:2], bus.out_valid, bus.in_ready},
            32'b10);
    end
    check("read_pulses", 32'(rd_cnt - rd0), 32'((!fault && op != 7) ? 1 : 0));
    check("write_pulses", 32'(wr_cnt - wr0), 32'((!fault && op >= 5) ? 1 : 0));
    if (!fault && op != 7)
      check("read_addr", last_rd_addr, 32'(a & ~3));
    if (!fault && op >= 5)
      check("write_data", last_wr_data, ref_word(a));

    bus.out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check("resp_done", {30'd0, bus.out_valid, bus.in_ready}, 32'b01);
  endtask

  initial begin
    logic [31:0] w;
    int          wr0, seen;
    bus.in_valid  = 1'b0;
    bus.in_op     = 3'd0;
    bus.in_addr   = 32'd0;
    bus.in_wdata  = 32'd0;
    bus.in_rd     = 5'd0;
    bus.out_ready = 1'b1;
    bus.ReadData  = 32'd0;

    for (int i = 0; i < 64; i++) begin
      w = $urandom;
      if (i == 5)  w = 32'h5555_5555;
      if (i == 10) w = 32'hAAAA_AAAA;
      dmem[i] = w;
      ref_mem[4*i]   = w[31:24];
      ref_mem[4*i+1] = w[23:16];
      ref_mem[4*i+2] = w[15:8];
      ref_mem[4*i+3] = w[7:0];
    end

    #2;
    check("rst_in_ready", 32'(bus.in_ready), 32'd1);
    check("rst_outs", {bus.out_valid, bus.out_is_load, bus.out_fault, bus.out_rd,
                       bus.MemRead, bus.MemWrite}, 32'd0);
    check("rst_out_data", bus.out_data, 32'd0);
    check("rst_address", bus.Address, 32'd0);
    check("rst_writedata", bus.WriteData, 32'd0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;

    run_req(4, 'h14, 32'd0, 5'd1, 0);
    run_req(0, 'h29, 32'd0, 5'd2, 0);
    run_req(1, 'h29, 32'd0, 5'd3, 0);
    run_req(2, 'h16, 32'd0, 5'd4, 0);
    run_req(5, 'h15, 32'h0000_0099, 5'd5, 0);
    run_req(4, 'h14, 32'd0, 5'd6, 0);

    // Reset during the WR cycle of an SH: write must be suppressed, no response
    @(negedge clk);
    bus.in_valid = 1'b1;
    bus.in_op    = 3'd6;
    bus.in_addr  = 32'h28;
    bus.in_wdata = 32'h0000_1234;
    @(posedge clk);
    #1 bus.in_valid = 1'b0;
    seen = 0;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      if (bus.MemWrite === 2'b01) begin
        seen = 1;
        break;
      end
    end
    check("sh_reached_wr", 32'(seen), 32'd1);
    wr0 = wr_cnt;
    #1 rst = 1'b1;
    #1 check("rst_drops_strobes", {28'd0, bus.MemRead, bus.MemWrite}, 32'd0);
    check("rst_no_valid", 32'(bus.out_valid), 32'd0);
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    check("post_rst_ready", 32'(bus.in_ready), 32'd1);
    @(negedge clk);
    check("post_rst_no_resp", 32'(bus.out_valid), 32'd0);
    check("rst_no_write", 32'(wr_cnt - wr0), 32'd0);
    run_req(4, 'h28, 32'd0, 5'd7, 0);

    run_req(7, 'h28, 32'hEEEE_EEEE, 5'd8, 5);
    run_req(4, 'h28, 32'd0, 5'd9, 0);
    run_req(2, 'h15, 32'd0, 5'd10, 0);
    run_req(4, 'h16, 32'd0, 5'd11, 0);
`ifdef MEM_ACCESS_BOUNDS_CHECK_EN
    run_req(4, 'h100, 32'd0, 5'd12, 0);
`endif

    for (int i = 0; i < 60; i++) begin
      run_req(int'($urandom_range(0, 7)), int'($urandom_range(0, 255)), $urandom,
              5'($urandom), int'($urandom_range(0, 2)));
    end

    check("no_overlap", 32'(both_cnt), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
